// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
// Byte lanes are big-endian: byte offset 0 lives in bits [31:24].
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;

    function automatic logic [3:0] be_for_offset(input logic [1:0] off);
        logic [3:0] be;
        case (off)
            2'd0:    be = BE_B0;
            2'd1:    be = BE_B1;
            2'd2:    be = BE_B2;
            default: be = BE_B3;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_lane.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational; store side is live, load side uses latched info.
module mem_byte_lane
    import mem_port_arbiter_pkg::*;
(
    input  logic        st_we,
    input  logic        st_byte,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_wdata,
    input  logic        ld_byte,
    input  logic        ld_sign,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0] ld_b;

    always_comb begin
        st_be         = BE_NONE;
        st_lane_wdata = st_wdata;
        if (st_we) begin
            if (st_byte) begin
                st_be         = be_for_offset(st_off);
                st_lane_wdata = {4{st_wdata[7:0]}};
            end else begin
                st_be = BE_WORD;
            end
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_b = ld_word[31:24];
            2'd1:    ld_b = ld_word[23:16];
            2'd2:    ld_b = ld_word[15:8];
            default: ld_b = ld_word[7:0];
        endcase
        ld_data = ld_word;
        if (ld_byte) begin
            ld_data = {{24{ld_sign & ld_b[7]}}, ld_b};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch and data stages,
// sequencing a fixed-latency memory and producing pipeline stall signals.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY   = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic        dm_signextend,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall_if,
    output logic        stall_dm,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    arb_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic        ld_byte_q, ld_byte_d;
    logic        ld_sign_q, ld_sign_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic [3:0]  st_be;
    logic [31:0] st_lane_wdata;
    logic [31:0] ld_data;
    logic        streak_sat;
    logic        last_cycle;
    logic        unused_ok;

    assign unused_ok  = ^if_addr[1:0];
    assign streak_sat = (streak_q == SW'(MAX_DM_STREAK));
    assign last_cycle = (cnt_q == CW'(MEM_LATENCY));

    mem_byte_lane u_lane (
        .st_we         (dm_we),
        .st_byte       (dm_byte),
        .st_off        (dm_addr[1:0]),
        .st_wdata      (dm_wdata),
        .st_be         (st_be),
        .st_lane_wdata (st_lane_wdata),
        .ld_byte       (ld_byte_q),
        .ld_sign       (ld_sign_q),
        .ld_off        (ld_off_q),
        .ld_word       (mem_rdata),
        .ld_data       (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        ld_byte_d  = ld_byte_q;
        ld_sign_d  = ld_sign_q;
        ld_off_d   = ld_off_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_en     = 1'b0;
        mem_be     = BE_NONE;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_ready   = 1'b0;
        dm_ready   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // rst gating keeps the command bus quiet while reset is held
                if (!rst && dm_req && !(if_req && streak_sat)) begin
                    state_d   = ARB_BUSY_DM;
                    cnt_d     = CW'(1);
                    streak_d  = streak_sat ? streak_q : streak_q + SW'(1);
                    ld_byte_d = dm_byte;
                    ld_sign_d = dm_signextend;
                    ld_off_d  = dm_addr[1:0];
                    mem_en    = 1'b1;
                    mem_addr  = dm_addr[31:2];
                    mem_be    = st_be;
                    mem_wdata = dm_we ? st_lane_wdata : '0;
                end else if (!rst && if_req) begin
                    state_d  = ARB_BUSY_IF;
                    cnt_d    = CW'(1);
                    streak_d = '0;
                    mem_en   = 1'b1;
                    mem_addr = if_addr[31:2];
                end
            end
            ARB_BUSY_IF: begin
                if (last_cycle) begin
                    if_ready   = 1'b1;
                    if_rdata_d = mem_rdata;
                    state_d    = ARB_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ARB_BUSY_DM: begin
                if (last_cycle) begin
                    dm_ready   = 1'b1;
                    dm_rdata_d = ld_data;
                    state_d    = ARB_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if_rdata = if_rdata_d;
        dm_rdata = dm_rdata_d;
    end

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            ld_byte_q  <= 1'b0;
            ld_sign_q  <= 1'b0;
            ld_off_q   <= 2'd0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            ld_byte_q  <= ld_byte_d;
            ld_sign_q  <= ld_sign_d;
            ld_off_q   <= ld_off_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule
